ehl_wdt_kicker: RTL and testbench
=================================

// Module: ehl_wdt_kicker
// PURPOSE
//   Bus-side controller for ehl_wdt. Shares the WDT register port between the CPU and a
//   hardware "kick" sequencer. The sequencer performs the atomic service sequence
//   UNLOCK -> LOAD reload value -> RELOCK, on request or on an internal periodic schedule.
//   It sits between the system register bus and the ehl_wdt wr/rd/addr/wdata/rdata port.
// PARAMETERS
//   WIDTH  32  WDT bus data width: 8, 16 or 32. Must match ehl_wdt WIDTH.
// PORTS
//   clk          in   1      system clock
//   reset_n      in   1      asynchronous active-low reset
//   cpu_wr       in   1      CPU write strobe; held until cpu_ready=1
//   cpu_rd       in   1      CPU read strobe; held until cpu_ready=1
//   cpu_addr     in   5      CPU register address
//   cpu_wdata    in   WIDTH  CPU write data
//   cpu_rdata    out  WIDTH  read data; direct copy of wdt_rdata
//   cpu_ready    out  1      1 = CPU access is forwarded this cycle
//   kick_req     in   1      single-cycle kick request
//   kick_load    in   32     reload value; latched when the sequence starts
//   auto_ena     in   1      enables periodic auto-kick
//   auto_period  in   32     auto-kick period in clk cycles; 0 = no auto-kicks
//   kick_busy    out  1      sequence in progress
//   kick_done    out  1      one-cycle pulse after the RELOCK write
//   wdt_wr       out  1      to ehl_wdt wr
//   wdt_rd       out  1      to ehl_wdt rd
//   wdt_addr     out  5      to ehl_wdt addr
//   wdt_wdata    out  WIDTH  to ehl_wdt wdata
//   wdt_rdata    in   WIDTH  from ehl_wdt rdata; valid the cycle after wdt_rd
// BEHAVIOUR
//   - Reset values: all outputs 0, except cpu_ready=1. FSM=IDLE, pending=0, auto counter=0.
//   - FSM states and transitions:
//       IDLE   -> UNLOCK  when pending=1 and no CPU access this cycle
//       UNLOCK -> LOAD    one cycle: wr LOCK (5'h08), wdata=8'hD9 (zero-extended)
//       LOAD   -> RELOCK  N=32/WIDTH cycles. Beat k writes addr 5'h00+k*(WIDTH/8),
//                         wdata=load_q[k*WIDTH +: WIDTH]; LSB beat first, MSB beat last
//       RELOCK -> DONE    one cycle: wr LOCK, wdata=0
//       DONE   -> IDLE    one cycle: kick_done=1; pending is cleared
//   - Latency: first wdt_wr occurs 1 cycle after pending is set. A sequence issues N+2
//     back-to-back writes; kick_done follows on the next cycle.
//   - kick_busy=1 in states UNLOCK..DONE.
//   - Arbitration:
//       cpu_ready = (state==IDLE) && !(pending && !cpu_wr && !cpu_rd)
//       In IDLE the CPU has priority. When cpu_ready=1, cpu_* pass combinationally to wdt_*.
//       A sequence is never interrupted. A CPU access arriving during a sequence is stalled,
//       then served in the first IDLE cycle.
//   - pending flag:
//       set by kick_req or by an auto-expiry; cleared in DONE.
//       A request arriving while pending or busy merges: exactly one extra sequence runs
//       after the current one if the request arrived during UNLOCK..DONE.
//   - Auto counter (32-bit):
//       counts only when auto_ena=1, auto_period!=0, and pending=0.
//       When count == auto_period-1: set pending, counter <= 0.
//       Cleared on kick_done and when auto_ena=0.
//       A manual kick therefore restarts the schedule.
//   - kick_load=0: written as-is; the WDT stops by its own definition.
//   - Simultaneous kick_req and cpu access in IDLE: CPU is served; the sequence starts
//     next cycle.
//   - Reset asserted mid-sequence: immediate return to reset values. The WDT may remain
//     unlocked; recovery is software's responsibility.
// STRUCTURE
//   - Package ehl_wdt_pkg holds:
//       register addresses LOAD=5'h00, VAL=5'h04, LOCK=5'h08, IRQ_CTRL=5'h0C, IRQ_FLAG=5'h10
//       UNLOCK_KEY=8'hD9, RELOCK_KEY=8'h00
//       kicker state encoding
//   - Sub-module ehl_wdt_kick_sched: auto counter plus pending logic.
//     FSM and bus mux stay in the top module.
// TESTING (bench instantiates ehl_wdt behind the kicker)
//   1. WIDTH=32, kick_req with kick_load=32'h100 -> wdt_wr on 3 consecutive cycles:
//      (08,D9), (00,00000100), (08,0). kick_done follows. LOCK reads 1; IRQ fires ~256 cycles later.
//   2. WIDTH=8, kick_load=32'h15141316 -> writes (08,D9), (00,16), (01,13), (02,14), (03,15), (08,00).
//      A LOAD read returns 32'h15141316.
//   3. CPU read of LOCK issued on the cycle UNLOCK starts -> cpu_ready=0 for the busy cycles.
//      The read completes after DONE and returns 1.
//   4. cpu_wr and kick_req in the same IDLE cycle -> CPU write first, sequence next cycle.
//      A second kick_req during LOAD -> exactly 2 kick_done pulses in total.
//   5. IRQ_CTRL=RST_ENA, auto_ena=1, auto_period=32'h40, kick_load=32'h100 -> no rst_req
//      over 4000 cycles. auto_period=0 -> no kicks, and rst_req is asserted within 300 cycles.
//   6. reset_n pulsed low after the UNLOCK write -> wdt_wr=0 and kick_busy=0 immediately.
//      After release: cpu_ready=1 and no sequence resumes.

Source files
------------

// File: rtl/ehl_wdt_pkg.sv
// ehl_wdt_pkg: shared register map, service keys and kicker state encoding for ehl_wdt.
package ehl_wdt_pkg;

    localparam logic [4:0] ADDR_LOAD     = 5'h00;
    localparam logic [4:0] ADDR_VAL      = 5'h04;
    localparam logic [4:0] ADDR_LOCK     = 5'h08;
    localparam logic [4:0] ADDR_IRQ_CTRL = 5'h0C;
    localparam logic [4:0] ADDR_IRQ_FLAG = 5'h10;

    localparam logic [7:0] UNLOCK_KEY = 8'hD9;
    localparam logic [7:0] RELOCK_KEY = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UNLOCK,
        ST_LOAD,
        ST_RELOCK,
        ST_DONE
    } kick_state_t;

endpackage

// File: rtl/ehl_wdt_kick_sched.sv
// ehl_wdt_kick_sched: periodic auto-kick counter and the pending/merge request flags.
module ehl_wdt_kick_sched (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        kick_req,
    input  logic        auto_ena,
    input  logic [31:0] auto_period,
    input  logic        busy,
    input  logic        done,
    output logic        pending
);

    logic [31:0] count;
    logic        extra;
    logic        run;
    logic        expire;

    assign run    = auto_ena && auto_period != '0 && !pending;
    assign expire = run && count == auto_period - 32'd1;

    // Auto schedule restarts after every completed kick and whenever it is disabled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else
            count <= (!auto_ena || done || expire) ? '0 : run ? count + 32'd1 : count;
    end

    // A request seen mid-sequence queues exactly one more sequence behind the current one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= 1'b0;
            extra   <= 1'b0;
        end else begin
            pending <= done ? (extra | kick_req) : (pending | kick_req | expire);
            extra   <= done ? 1'b0 : (extra | (busy & kick_req));
        end
    end

endmodule

// File: rtl/ehl_wdt_kicker.sv
// ehl_wdt_kicker: arbitrates the ehl_wdt register port between the CPU and an atomic kick sequencer.
module ehl_wdt_kicker
    import ehl_wdt_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cpu_wr,
    input  logic             cpu_rd,
    input  logic [4:0]       cpu_addr,
    input  logic [WIDTH-1:0] cpu_wdata,
    output logic [WIDTH-1:0] cpu_rdata,
    output logic             cpu_ready,
    input  logic             kick_req,
    input  logic [31:0]      kick_load,
    input  logic             auto_ena,
    input  logic [31:0]      auto_period,
    output logic             kick_busy,
    output logic             kick_done,
    output logic             wdt_wr,
    output logic             wdt_rd,
    output logic [4:0]       wdt_addr,
    output logic [WIDTH-1:0] wdt_wdata,
    input  logic [WIDTH-1:0] wdt_rdata
);

    localparam int N     = 32 / WIDTH;
    localparam int BYTES = WIDTH / 8;

    kick_state_t state, state_nx;
    logic [1:0]  beat;
    logic [31:0] load_q;
    logic        pending;
    logic        cpu_acc;
    logic        last_beat;

    assign cpu_acc   = cpu_wr | cpu_rd;
    assign last_beat = beat == 2'(N - 1);
    assign kick_busy = state != ST_IDLE;
    assign cpu_rdata = wdt_rdata;

    ehl_wdt_kick_sched u_sched (
        .clk         (clk),
        .reset_n     (reset_n),
        .kick_req    (kick_req),
        .auto_ena    (auto_ena),
        .auto_period (auto_period),
        .busy        (kick_busy),
        .done        (kick_done),
        .pending     (pending)
    );

    // State register, LOAD beat index, and reload value captured as the sequence starts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            beat   <= '0;
            load_q <= '0;
        end else begin
            state  <= state_nx;
            beat   <= (state == ST_LOAD) ? beat + 2'd1 : '0;
            load_q <= (state == ST_IDLE && state_nx == ST_UNLOCK) ? kick_load : load_q;
        end
    end

    // Next state and bus mux: CPU passes through only in IDLE, sequencer owns the port otherwise.
    always_comb begin
        state_nx  = state;
        cpu_ready = 1'b0;
        kick_done = 1'b0;
        wdt_wr    = 1'b0;
        wdt_rd    = 1'b0;
        wdt_addr  = '0;
        wdt_wdata = '0;
        case (state)
            ST_IDLE: begin
                cpu_ready = !(pending && !cpu_acc);
                wdt_wr    = cpu_ready & cpu_wr;
                wdt_rd    = cpu_ready & cpu_rd;
                wdt_addr  = (cpu_ready && cpu_acc) ? cpu_addr : '0;
                wdt_wdata = (cpu_ready && cpu_acc) ? cpu_wdata : '0;
                state_nx  = (pending && !cpu_acc) ? ST_UNLOCK : ST_IDLE;
            end
            ST_UNLOCK: begin
                wdt_wr    = 1'b1;
                wdt_addr  = ADDR_LOCK;
                wdt_wdata = WIDTH'(UNLOCK_KEY);
                state_nx  = ST_LOAD;
            end
            ST_LOAD: begin
                wdt_wr    = 1'b1;
                wdt_addr  = ADDR_LOAD + 5'(32'(beat) * BYTES);
                wdt_wdata = WIDTH'(load_q >> (32'(beat) * WIDTH));
                state_nx  = last_beat ? ST_RELOCK : ST_LOAD;
            end
            ST_RELOCK: begin
                wdt_wr    = 1'b1;
                wdt_addr  = ADDR_LOCK;
                wdt_wdata = WIDTH'(RELOCK_KEY);
                state_nx  = ST_DONE;
            end
            ST_DONE: begin
                kick_done = 1'b1;
                state_nx  = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ehl_wdt_kicker.sv
// tb_ehl_wdt_kicker: directed checks of the kicker against a small register-port model of ehl_wdt.
module tb_ehl_wdt_kicker;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_wr = 1'b0, cpu_rd = 1'b0;
    logic [4:0]  cpu_addr = '0;
    logic [31:0] cpu_wdata = '0, cpu_rdata;
    logic        cpu_ready;
    logic        kick_req = 1'b0;
    logic [31:0] kick_load = '0;
    logic        auto_ena = 1'b0;
    logic [31:0] auto_period = '0;
    logic        kick_busy, kick_done;
    logic        wdt_wr, wdt_rd;
    logic [4:0]  wdt_addr;
    logic [31:0] wdt_wdata;
    logic [31:0] wdt_rdata = '0;

    logic        b_kick_req = 1'b0;
    logic [31:0] b_kick_load = '0;
    logic        b_zero = 1'b0;
    logic [4:0]  b_addr0 = '0;
    logic [7:0]  b_wd0 = '0, b_rdata = '0, b_cpu_rdata;
    logic        b_cpu_ready, b_kick_busy, b_kick_done;
    logic        b_wdt_wr, b_wdt_rd;
    logic [4:0]  b_wdt_addr;
    logic [7:0]  b_wdt_wdata;

    int checks = 0, failures = 0;
    int dones = 0, m_exp = 0;
    logic        m_unl = 1'b0;
    logic [31:0] m_load = '0, m_cnt = '0;
    logic        b_unl = 1'b0;
    logic [31:0] b_load = '0;

    always #5 clk = ~clk;

    ehl_wdt_kicker #(.WIDTH(32)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .kick_req(kick_req), .kick_load(kick_load), .auto_ena(auto_ena), .auto_period(auto_period),
        .kick_busy(kick_busy), .kick_done(kick_done),
        .wdt_wr(wdt_wr), .wdt_rd(wdt_rd), .wdt_addr(wdt_addr), .wdt_wdata(wdt_wdata),
        .wdt_rdata(wdt_rdata)
    );

    ehl_wdt_kicker #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset_n(reset_n),
        .cpu_wr(b_zero), .cpu_rd(b_zero), .cpu_addr(b_addr0), .cpu_wdata(b_wd0),
        .cpu_rdata(b_cpu_rdata), .cpu_ready(b_cpu_ready),
        .kick_req(b_kick_req), .kick_load(b_kick_load), .auto_ena(b_zero), .auto_period(32'd0),
        .kick_busy(b_kick_busy), .kick_done(b_kick_done),
        .wdt_wr(b_wdt_wr), .wdt_rd(b_wdt_rd), .wdt_addr(b_wdt_addr), .wdt_wdata(b_wdt_wdata),
        .wdt_rdata(b_rdata)
    );

    // Minimal 32-bit WDT: key-gated LOAD, LOCK reads 1 when locked, down counter with expiry count.
    always @(posedge clk) begin
        if (wdt_rd) wdt_rdata <= (wdt_addr == 5'h08) ? {31'b0, !m_unl} : m_load;
        if (wdt_wr && wdt_addr == 5'h08) m_unl <= (wdt_wdata == 32'hD9);
        if (wdt_wr && wdt_addr == 5'h00 && m_unl) begin
            m_load <= wdt_wdata;
            m_cnt  <= wdt_wdata;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) m_exp <= m_exp + 1;
        end
        if (kick_done) dones <= dones + 1;
    end

    // Minimal 8-bit WDT: byte lanes of LOAD at addresses 0..3.
    always @(posedge clk) begin
        if (b_wdt_wr && b_wdt_addr == 5'h08) b_unl <= (b_wdt_wdata == 8'hD9);
        if (b_wdt_wr && b_wdt_addr < 5'h04 && b_unl) b_load[b_wdt_addr[1:0]*8 +: 8] <= b_wdt_wdata;
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc(int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic exp_wr(string tag, logic [4:0] a, logic [31:0] d);
        check({tag, "_wr"}, 32'(wdt_wr), 1);
        check({tag, "_addr"}, 32'(wdt_addr), 32'(a));
        check({tag, "_wdata"}, wdt_wdata, d);
    endtask

    initial begin
        int d0, e0;
        logic [4:0] ea [6] = '{5'h08, 5'h00, 5'h01, 5'h02, 5'h03, 5'h08};
        logic [7:0] ed [6] = '{8'hD9, 8'h16, 8'h13, 8'h14, 8'h15, 8'h00};

        cyc(2);
        #1;
        check("rst_cpu_ready", 32'(cpu_ready), 1);
        check("rst_busy", 32'(kick_busy), 0);
        check("rst_wr", 32'(wdt_wr), 0);
        check("rst_done", 32'(kick_done), 0);
        check("rst_addr", 32'(wdt_addr), 0);
        reset_n = 1'b1;

        // basic 32-bit kick
        cyc; kick_req = 1'b1; kick_load = 32'h100; #1;
        check("t1_idle_ready", 32'(cpu_ready), 1);
        check("t1_idle_wr", 32'(wdt_wr), 0);
        cyc; kick_req = 1'b0; #1;
        check("t1_pend_ready", 32'(cpu_ready), 0);
        check("t1_pend_busy", 32'(kick_busy), 0);
        cyc; #1;
        exp_wr("t1_unlock", 5'h08, 32'hD9);
        check("t1_unlock_busy", 32'(kick_busy), 1);
        cyc; #1;
        exp_wr("t1_load", 5'h00, 32'h100);
        cyc; #1;
        exp_wr("t1_relock", 5'h08, 32'h0);
        cyc; #1;
        check("t1_done", 32'(kick_done), 1);
        check("t1_done_wr", 32'(wdt_wr), 0);
        check("t1_done_busy", 32'(kick_busy), 1);
        cyc; cpu_rd = 1'b1; cpu_addr = 5'h08; #1;
        check("t1_after_done", 32'(kick_done), 0);
        check("t1_after_ready", 32'(cpu_ready), 1);
        check("t1_after_rd", 32'(wdt_rd), 1);
        cyc; cpu_rd = 1'b0; #1;
        check("t1_lock_read", cpu_rdata, 1);
        check("t1_model_load", m_load, 32'h100);

        // CPU read stalled by a sequence
        cyc; kick_req = 1'b1;
        cyc; kick_req = 1'b0;
        cyc; cpu_rd = 1'b1; cpu_addr = 5'h08; #1;
        check("t3_unlock_ready", 32'(cpu_ready), 0);
        check("t3_unlock_rd", 32'(wdt_rd), 0);
        check("t3_unlock_wr", 32'(wdt_wr), 1);
        for (int i = 0; i < 3; i++) begin
            cyc; #1;
            check("t3_stall_ready", 32'(cpu_ready), 0);
            check("t3_stall_rd", 32'(wdt_rd), 0);
        end
        check("t3_done", 32'(kick_done), 1);
        cyc; #1;
        check("t3_serve_ready", 32'(cpu_ready), 1);
        check("t3_serve_rd", 32'(wdt_rd), 1);
        check("t3_serve_addr", 32'(wdt_addr), 32'h08);
        cyc; cpu_rd = 1'b0; #1;
        check("t3_lock_read", cpu_rdata, 1);

        // CPU write wins over a simultaneous kick; a second kick during LOAD merges
        cyc; d0 = dones;
        cpu_wr = 1'b1; cpu_addr = 5'h0C; cpu_wdata = 32'h5; kick_req = 1'b1; #1;
        check("t4_cpu_ready", 32'(cpu_ready), 1);
        exp_wr("t4_cpu", 5'h0C, 32'h5);
        cyc; cpu_wr = 1'b0; kick_req = 1'b0; #1;
        check("t4_pend_ready", 32'(cpu_ready), 0);
        check("t4_pend_wr", 32'(wdt_wr), 0);
        cyc; #1;
        exp_wr("t4_unlock", 5'h08, 32'hD9);
        cyc; kick_req = 1'b1; #1;
        exp_wr("t4_load", 5'h00, 32'h100);
        cyc; kick_req = 1'b0;
        cyc(15); #1;
        check("t4_two_dones", 32'(dones - d0), 2);
        check("t4_idle", 32'(kick_busy), 0);

        // WIDTH=8 sequence: byte beats LSB first
        b_kick_req = 1'b1; b_kick_load = 32'h15141316;
        cyc; b_kick_req = 1'b0; #1;
        check("t2_pend_wr", 32'(b_wdt_wr), 0);
        for (int i = 0; i < 6; i++) begin
            cyc; #1;
            check($sformatf("t2_wr%0d", i), 32'(b_wdt_wr), 1);
            check($sformatf("t2_addr%0d", i), 32'(b_wdt_addr), 32'(ea[i]));
            check($sformatf("t2_wdata%0d", i), 32'(b_wdt_wdata), 32'(ed[i]));
        end
        cyc; #1;
        check("t2_done", 32'(b_kick_done), 1);
        check("t2_load", b_load, 32'h15141316);

        // auto-kick keeps the watchdog alive; period 0 lets it expire
        auto_ena = 1'b1; auto_period = 32'h40; kick_load = 32'h100;
        d0 = dones; e0 = m_exp;
        cyc(4000); #1;
        check("t5_no_expiry", 32'(m_exp - e0), 0);
        check("t5_kick_count", 32'((dones - d0) >= 56 && (dones - d0) <= 59), 1);
        auto_period = 32'h0;
        cyc(10); d0 = dones; e0 = m_exp;
        cyc(300); #1;
        check("t5_p0_no_kicks", 32'(dones - d0), 0);
        check("t5_p0_expiry", 32'(m_exp - e0), 1);
        auto_ena = 1'b0;

        // reset mid-sequence
        cyc; d0 = dones; kick_req = 1'b1;
        cyc; kick_req = 1'b0;
        cyc; #1;
        exp_wr("t6_unlock", 5'h08, 32'hD9);
        cyc; reset_n = 1'b0; #1;
        check("t6_rst_wr", 32'(wdt_wr), 0);
        check("t6_rst_busy", 32'(kick_busy), 0);
        cyc; reset_n = 1'b1;
        cyc(10); #1;
        check("t6_ready", 32'(cpu_ready), 1);
        check("t6_busy", 32'(kick_busy), 0);
        check("t6_no_done", 32'(dones - d0), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
